// File: rtl/difftest_sim_ctrl_pkg.sv
// Shared types and codes for the difftest simulation sequencer:
// FSM states, step/done status encodings and the status mapping helper.
package difftest_sim_ctrl_pkg;

  typedef enum logic [2:0] {
    RST_HOLD  = 3'd0,
    INIT      = 3'd1,
    RUN       = 3'd2,
    WAIT_STEP = 3'd3,
    DONE      = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SS_CONTINUE = 2'd0,
    SS_GOOD     = 2'd1,
    SS_BAD      = 2'd2,
    SS_ABORT    = 2'd3
  } step_status_e;

  localparam logic [2:0] DS_RUNNING = 3'd0;
  localparam logic [2:0] DS_GOOD    = 3'd1;
  localparam logic [2:0] DS_BAD     = 3'd2;
  localparam logic [2:0] DS_ABORT   = 3'd3;
  localparam logic [2:0] DS_MAXCYC  = 3'd4;

  // Non-continue step codes map one-to-one onto the low done_status codes.
  function automatic logic [2:0] done_code(input logic [1:0] step_status);
    return {1'b0, step_status};
  endfunction

endpackage

// File: rtl/difftest_sim_ctrl_uart_fifo.sv
// Synchronous FIFO buffering DUT UART characters for the host; pushes into
// a full FIFO are dropped (sticky overflow) unless a pop frees a slot.
module sim_uart_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_valid;
  logic          r_overflow;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push_ok;
  logic [CW-1:0] w_count_nxt;

  // Handshake decode: a pop from a full FIFO makes room for a same-cycle push.
  always_comb begin
    w_empty   = (r_count == CW'(0));
    w_full    = (r_count == CW'(DEPTH));
    w_pop     = !w_empty && i_ready;
    w_push_ok = i_push && (!w_full || w_pop);
    case ({w_push_ok, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array, written only on accepted pushes.
  always_ff @(posedge clock) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers, occupancy and flags.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != CW'(0));
      if (i_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_data     = r_mem[r_rd_ptr];
  assign o_overflow = r_overflow;

endmodule

// File: rtl/difftest_sim_ctrl.sv
// Lock-step simulation sequencer between the host harness and SimTop:
// reset hold, init handshake, single-cycle DUT steps, limits, logs, perf and UART.
module difftest_sim_ctrl
  import difftest_sim_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = 16,
  parameter int CYCLE_W      = 64,
  parameter int UART_DEPTH   = 16,
  parameter int PERF_W       = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [CYCLE_W-1:0] cfg_max_cycles,
  input  logic [CYCLE_W-1:0] cfg_log_begin,
  input  logic [CYCLE_W-1:0] cfg_log_end,
  input  logic [PERF_W-1:0]  cfg_perf_interval,
  output logic               dut_reset,
  output logic               dut_clk_en,
  output logic               init_req,
  input  logic               init_ack,
  output logic               step_req,
  input  logic               step_ack,
  input  logic [1:0]         step_status,
  output logic [CYCLE_W-1:0] cycle_cnt,
  output logic               log_enable,
  output logic               perf_dump,
  input  logic               dut_uart_valid,
  input  logic [7:0]         dut_uart_ch,
  output logic               uart_out_valid,
  output logic [7:0]         uart_out_ch,
  input  logic               uart_out_ready,
  output logic               uart_overflow,
  output logic               done,
  output logic [2:0]         done_status
);
  localparam int RW = $clog2(RESET_CYCLES + 1);

  state_e             r_state;
  logic [RW-1:0]      r_rst_cnt;
  logic               r_dut_reset;
  logic               r_dut_clk_en;
  logic               r_init_req;
  logic               r_step_req;
  logic [CYCLE_W-1:0] r_cycle_cnt;
  logic [PERF_W-1:0]  r_perf_cnt;
  logic               r_perf_dump;
  logic               r_log_enable;
  logic               r_done;
  logic [2:0]         r_done_status;

  logic [CYCLE_W-1:0] w_cycle_nxt;
  logic               w_log_nxt;
  logic               w_uart_push;

  // Log window is judged on the count the register will hold next cycle.
  always_comb begin
    if (r_state == RUN) begin
      w_cycle_nxt = r_cycle_cnt + CYCLE_W'(1);
    end else begin
      w_cycle_nxt = r_cycle_cnt;
    end
    w_log_nxt   = (w_cycle_nxt >= cfg_log_begin) && (w_cycle_nxt < cfg_log_end);
    w_uart_push = r_dut_clk_en && dut_uart_valid;
  end

  // Sequencer FSM with all handshake and status outputs registered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= RST_HOLD;
      r_rst_cnt     <= '0;
      r_dut_reset   <= 1'b1;
      r_dut_clk_en  <= 1'b0;
      r_init_req    <= 1'b0;
      r_step_req    <= 1'b0;
      r_cycle_cnt   <= '0;
      r_perf_cnt    <= '0;
      r_perf_dump   <= 1'b0;
      r_log_enable  <= 1'b0;
      r_done        <= 1'b0;
      r_done_status <= DS_RUNNING;
    end else begin
      r_perf_dump  <= 1'b0;
      r_log_enable <= w_log_nxt;
      case (r_state)
        RST_HOLD: begin
          if (r_rst_cnt == RW'(RESET_CYCLES - 1)) begin
            r_state     <= INIT;
            r_dut_reset <= 1'b0;
            r_init_req  <= 1'b1;
          end else begin
            r_rst_cnt <= r_rst_cnt + RW'(1);
          end
        end
        INIT: begin
          if (init_ack) begin
            r_state      <= RUN;
            r_init_req   <= 1'b0;
            r_dut_clk_en <= 1'b1;
            r_perf_cnt   <= cfg_perf_interval - PERF_W'(1);
          end
        end
        RUN: begin
          r_state      <= WAIT_STEP;
          r_dut_clk_en <= 1'b0;
          r_step_req   <= 1'b1;
          r_cycle_cnt  <= w_cycle_nxt;
          if (cfg_perf_interval != PERF_W'(0)) begin
            if (r_perf_cnt == PERF_W'(0)) begin
              r_perf_dump <= 1'b1;
              r_perf_cnt  <= cfg_perf_interval - PERF_W'(1);
            end else begin
              r_perf_cnt <= r_perf_cnt - PERF_W'(1);
            end
          end
        end
        WAIT_STEP: begin
          if (step_ack) begin
            r_step_req <= 1'b0;
            if (step_status != SS_CONTINUE) begin
              r_state       <= DONE;
              r_done        <= 1'b1;
              r_done_status <= done_code(step_status);
            end else if ((cfg_max_cycles != CYCLE_W'(0)) && (r_cycle_cnt >= cfg_max_cycles)) begin
              r_state       <= DONE;
              r_done        <= 1'b1;
              r_done_status <= DS_MAXCYC;
            end else begin
              r_state      <= RUN;
              r_dut_clk_en <= 1'b1;
            end
          end
        end
        DONE: begin
          r_dut_clk_en <= 1'b0;
          r_init_req   <= 1'b0;
          r_step_req   <= 1'b0;
        end
        default: begin
          r_state      <= RST_HOLD;
          r_rst_cnt    <= '0;
          r_dut_reset  <= 1'b1;
          r_dut_clk_en <= 1'b0;
          r_init_req   <= 1'b0;
          r_step_req   <= 1'b0;
        end
      endcase
    end
  end

  sim_uart_fifo #(
    .DEPTH (UART_DEPTH),
    .DW    (8)
  ) u_uart_fifo (
    .clock      (clock),
    .reset      (reset),
    .i_push     (w_uart_push),
    .i_data     (dut_uart_ch),
    .i_ready    (uart_out_ready),
    .o_valid    (uart_out_valid),
    .o_data     (uart_out_ch),
    .o_overflow (uart_overflow)
  );

  assign dut_reset   = r_dut_reset;
  assign dut_clk_en  = r_dut_clk_en;
  assign init_req    = r_init_req;
  assign step_req    = r_step_req;
  assign cycle_cnt   = r_cycle_cnt;
  assign log_enable  = r_log_enable;
  assign perf_dump   = r_perf_dump;
  assign done        = r_done;
  assign done_status = r_done_status;

endmodule

// File: tb/tb_difftest_sim_ctrl.sv
// Directed bench for difftest_sim_ctrl: reset/init timing, step limits,
// trap and mid-step reset, log window, perf pulses and UART FIFO edge cases.
module tb_difftest_sim_ctrl;
  logic        clock;
  logic        reset;
  logic [63:0] cfg_max_cycles;
  logic [63:0] cfg_log_begin;
  logic [63:0] cfg_log_end;
  logic [31:0] cfg_perf_interval;
  logic        dut_reset;
  logic        dut_clk_en;
  logic        init_req;
  logic        init_ack;
  logic        step_req;
  logic        step_ack;
  logic [1:0]  step_status;
  logic [63:0] cycle_cnt;
  logic        log_enable;
  logic        perf_dump;
  logic        dut_uart_valid;
  logic [7:0]  dut_uart_ch;
  logic        uart_out_valid;
  logic [7:0]  uart_out_ch;
  logic        uart_out_ready;
  logic        uart_overflow;
  logic        done;
  logic [2:0]  done_status;

  int          n_checks;
  int          n_pass;
  int          clk_cnt;
  int          ack_cnt;
  logic [31:0] log_obs;
  logic [31:0] perf_obs;
  logic [7:0]  rx [32];

  difftest_sim_ctrl dut (
    .clock             (clock),
    .reset             (reset),
    .cfg_max_cycles    (cfg_max_cycles),
    .cfg_log_begin     (cfg_log_begin),
    .cfg_log_end       (cfg_log_end),
    .cfg_perf_interval (cfg_perf_interval),
    .dut_reset         (dut_reset),
    .dut_clk_en        (dut_clk_en),
    .init_req          (init_req),
    .init_ack          (init_ack),
    .step_req          (step_req),
    .step_ack          (step_ack),
    .step_status       (step_status),
    .cycle_cnt         (cycle_cnt),
    .log_enable        (log_enable),
    .perf_dump         (perf_dump),
    .dut_uart_valid    (dut_uart_valid),
    .dut_uart_ch       (dut_uart_ch),
    .uart_out_valid    (uart_out_valid),
    .uart_out_ch       (uart_out_ch),
    .uart_out_ready    (uart_out_ready),
    .uart_overflow     (uart_overflow),
    .done              (done),
    .done_status       (done_status)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hold_reset();
    @(negedge clock);
    reset    = 1'b0;
    init_ack = 1'b0;
    step_ack = 1'b0;
    @(negedge clock);
    @(negedge clock);
  endtask

  // Release reset, count dut_reset cycles, ack init on its third request cycle.
  task automatic release_init(output int n_rst, output int n_init);
    int guard;
    reset = 1'b1;
    n_rst = 0;
    while (dut_reset && n_rst < 100) begin
      n_rst++;
      @(negedge clock);
    end
    n_init = 0;
    guard  = 0;
    while (n_init < 3 && guard < 100) begin
      if (init_req) n_init++;
      if (n_init == 3) init_ack = 1'b1;
      @(negedge clock);
      guard++;
    end
    init_ack = 1'b0;
  endtask

  // Auto-ack every step request; optional trap status, stop point and one pop.
  task automatic run_steps(input int ack_limit, input int stop_at, input logic [1:0] st,
                           input int pop_at);
    int cyc;
    clk_cnt  = 0;
    ack_cnt  = 0;
    log_obs  = '0;
    perf_obs = '0;
    cyc      = 0;
    while (!done && cyc < 2000) begin
      step_ack       = 1'b0;
      step_status    = 2'd0;
      uart_out_ready = 1'b0;
      if (dut_clk_en) begin
        clk_cnt++;
        dut_uart_ch = (clk_cnt == pop_at) ? 8'h5A : 8'(8'h41 + clk_cnt - 1);
        if (clk_cnt == pop_at) uart_out_ready = 1'b1;
      end
      if (perf_dump && clk_cnt < 32) perf_obs[clk_cnt] = 1'b1;
      if (step_req) begin
        if (ack_cnt == ack_limit) break;
        if (clk_cnt < 32) log_obs[clk_cnt] = log_enable;
        ack_cnt++;
        step_ack = 1'b1;
        if (ack_cnt == stop_at) step_status = st;
      end
      @(negedge clock);
      cyc++;
    end
    step_ack       = 1'b0;
    step_status    = 2'd0;
    uart_out_ready = 1'b0;
    check_val("run_bound", 64'(cyc < 2000), 64'd1);
  endtask

  task automatic count_clk_en(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      if (dut_clk_en) c++;
      @(negedge clock);
    end
  endtask

  task automatic drain(output int n);
    n = 0;
    uart_out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (uart_out_valid && n < 32) begin
        rx[n] = uart_out_ch;
        n++;
      end
      @(negedge clock);
    end
    uart_out_ready = 1'b0;
  endtask

  initial begin
    int n_rst;
    int n_init;
    int c;
    int n;
    n_checks          = 0;
    n_pass            = 0;
    reset             = 1'b0;
    cfg_max_cycles    = 64'd0;
    cfg_log_begin     = 64'd0;
    cfg_log_end       = 64'd0;
    cfg_perf_interval = 32'd0;
    init_ack          = 1'b0;
    step_ack          = 1'b0;
    step_status       = 2'd0;
    dut_uart_valid    = 1'b0;
    dut_uart_ch       = 8'h00;
    uart_out_ready    = 1'b0;

    // Reset state and init handshake timing
    cfg_max_cycles = 64'd5;
    hold_reset();
    check_val("rst_dut_reset", 64'(dut_reset), 64'd1);
    check_val("rst_cycle_cnt", cycle_cnt, 64'd0);
    check_val("rst_init_req", 64'(init_req), 64'd0);
    check_val("rst_clk_en", 64'(dut_clk_en), 64'd0);
    check_val("rst_done", 64'({done, done_status}), 64'd0);
    check_val("rst_uart_valid", 64'(uart_out_valid), 64'd0);
    release_init(n_rst, n_init);
    check_val("dut_reset_cycles", 64'(n_rst), 64'd16);
    check_val("init_req_cycles", 64'(n_init), 64'd3);
    check_val("init_req_low", 64'(init_req), 64'd0);
    check_val("first_clk_en", 64'(dut_clk_en), 64'd1);

    // Max-cycle limit
    run_steps(-1, 0, 2'd0, 0);
    check_val("max_clk_pulses", 64'(clk_cnt), 64'd5);
    check_val("max_cycle_cnt", cycle_cnt, 64'd5);
    check_val("max_done", 64'(done), 64'd1);
    check_val("max_status", 64'(done_status), 64'd4);
    count_clk_en(5, c);
    check_val("max_idle_clk_en", 64'(c), 64'd0);
    check_val("max_no_step_req", 64'(step_req), 64'd0);

    // Good trap on third ack, then reset in the middle of WAIT_STEP
    cfg_max_cycles = 64'd0;
    hold_reset();
    release_init(n_rst, n_init);
    run_steps(-1, 3, 2'd1, 0);
    check_val("trap_status", 64'(done_status), 64'd1);
    check_val("trap_cycle_cnt", cycle_cnt, 64'd3);
    count_clk_en(5, c);
    check_val("trap_idle_clk_en", 64'(c), 64'd0);
    hold_reset();
    release_init(n_rst, n_init);
    run_steps(2, 0, 2'd0, 0);
    check_val("mid_step_req", 64'(step_req), 64'd1);
    check_val("mid_cycle_cnt", cycle_cnt, 64'd3);
    reset    = 1'b0;
    step_ack = 1'b1;
    @(negedge clock);
    step_ack = 1'b0;
    check_val("mid_rst_dut_reset", 64'(dut_reset), 64'd1);
    check_val("mid_rst_cycle_cnt", cycle_cnt, 64'd0);
    check_val("mid_rst_step_req", 64'(step_req), 64'd0);
    check_val("mid_rst_done", 64'(done), 64'd0);

    // Log window [2,4) and perf interval 3 over 10 DUT cycles
    cfg_max_cycles    = 64'd10;
    cfg_log_begin     = 64'd2;
    cfg_log_end       = 64'd4;
    cfg_perf_interval = 32'd3;
    hold_reset();
    check_val("rst_log_enable", 64'(log_enable), 64'd0);
    release_init(n_rst, n_init);
    run_steps(-1, 0, 2'd0, 0);
    check_val("log_window", 64'(log_obs), 64'h0000_000C);
    check_val("perf_pulses", 64'(perf_obs), 64'h0000_0248);
    check_val("log_perf_cycle_cnt", cycle_cnt, 64'd10);

    // UART overflow: 20 characters into 16 entries, then drain in order
    cfg_max_cycles    = 64'd20;
    cfg_log_begin     = 64'd0;
    cfg_log_end       = 64'd0;
    cfg_perf_interval = 32'd0;
    dut_uart_valid    = 1'b1;
    hold_reset();
    release_init(n_rst, n_init);
    run_steps(-1, 0, 2'd0, 0);
    check_val("ovf_flag", 64'(uart_overflow), 64'd1);
    check_val("ovf_valid", 64'(uart_out_valid), 64'd1);
    check_val("ovf_no_perf", 64'(perf_obs), 64'd0);
    drain(n);
    check_val("ovf_drain_count", 64'(n), 64'd16);
    for (int i = 0; i < 16; i++) begin
      check_val($sformatf("ovf_drain_%0d", i), 64'(rx[i]), 64'(8'h41 + i));
    end
    check_val("ovf_sticky", 64'(uart_overflow), 64'd1);

    // Full FIFO with simultaneous push of 0x5A and pop
    cfg_max_cycles = 64'd17;
    hold_reset();
    check_val("rst_overflow", 64'(uart_overflow), 64'd0);
    check_val("rst_fifo_empty", 64'(uart_out_valid), 64'd0);
    release_init(n_rst, n_init);
    run_steps(-1, 0, 2'd0, 17);
    dut_uart_valid = 1'b0;
    check_val("full_pp_no_ovf", 64'(uart_overflow), 64'd0);
    drain(n);
    check_val("full_pp_count", 64'(n), 64'd16);
    check_val("full_pp_first", 64'(rx[0]), 64'h42);
    check_val("full_pp_mid", 64'(rx[14]), 64'h50);
    check_val("full_pp_last", 64'(rx[15]), 64'h5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
